// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display driver.
package seg_pkg;

    // Default scan period: 1 ms per digit at 100 MHz.
    localparam int SCAN_DIV_DEFAULT = 100000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_COMMIT
    } state_t;

    // One display position: a blank flag overrides the nibble.
    typedef struct packed {
        logic       blank;
        logic [3:0] val;
    } digit_t;

    localparam digit_t DIGIT_BLANK = '{blank: 1'b1, val: 4'd0};
    localparam digit_t DIGIT_ZERO  = '{blank: 1'b0, val: 4'd0};

    // Segment order {a,b,c,d,e,f,g,dp}, active high, dp never lit.
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] HEX_GLYPH [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2,   // 0 1 2 3
        8'h66, 8'hB6, 8'hBE, 8'hE0,   // 4 5 6 7
        8'hFE, 8'hF6, 8'hEE, 8'h3E,   // 8 9 A b
        8'h9C, 8'h7A, 8'h9E, 8'h8E    // C d E F
    };

    function automatic digit_t mk_digit(input logic blank, input logic [3:0] val);
        digit_t d;
        d.blank = blank;
        d.val   = val;
        return d;
    endfunction

endpackage

// File: rtl/seg_display_driver_if.sv
// Load/busy handshake between a value source and the display driver.
interface seg_display_driver_if;
    logic [7:0] value;
    logic       load;
    logic       mode_dec;
    logic       busy;

    modport master (output value, output load, output mode_dec, input  busy);
    modport slave  (input  value, input  load, input  mode_dec, output busy);
endinterface

// File: rtl/bin2bcd_iter.sv
// Iterative 8-bit binary to 3-digit BCD converter (double dabble), one bit per cycle.
module bin2bcd_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);
    logic [7:0]  shift_bin;
    logic [11:0] bcd_acc;
    logic [11:0] bcd_adj;
    logic [2:0]  step;
    logic        running;

    // Add 3 to every BCD nibble of 5 or more so the following shift carries correctly.
    always_comb begin
        // NOTE: default first so every path assigns bcd_adj; otherwise a latch is inferred.
        bcd_adj = bcd_acc;
        for (int i = 0; i < 3; i++) begin
            if (bcd_acc[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_acc[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Load the operand on start, then correct-and-shift once per cycle for 8 cycles.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            running   <= 1'b0;
            step      <= 3'd0;
            shift_bin <= 8'd0;
            bcd_acc   <= 12'd0;
        end else if (start) begin
            running   <= 1'b1;
            step      <= 3'd0;
            shift_bin <= bin;
            bcd_acc   <= 12'd0;
        end else if (running) begin
            {bcd_acc, shift_bin} <= {bcd_adj, shift_bin} << 1;
            step <= step + 3'd1;
            if (step == 3'd7) begin
                running <= 1'b0;
            end
        end
    end

    // done marks the cycle whose edge performs the final shift; bcd is valid after it.
    assign done = running && (step == 3'd7);
    assign bcd  = bcd_acc;

endmodule

// File: rtl/seg_display_driver.sv
// Four-digit multiplexed seven-segment driver with hex and decimal display modes.
module seg_display_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV   = SCAN_DIV_DEFAULT,
    parameter int NUM_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_display_driver_if.slave   bus,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0] scan_cnt;
    logic [IDX_W-1:0] digit_idx;
    digit_t           digits [NUM_DIGITS];

    state_t      state, state_next;
    logic        conv_start;
    logic        conv_done;
    logic        hex_load;
    logic        commit;
    logic [11:0] bcd;
    logic [3:0]  hund, tens, ones;

    // Free-running scan: each digit is lit for SCAN_DIV cycles, untouched by loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 1'b1;
        end else begin
            scan_cnt  <= scan_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and control strobes; loads are only acted on in IDLE.
    always_comb begin
        state_next = state;
        conv_start = 1'b0;
        hex_load   = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.load) begin
                    if (bus.mode_dec) begin
                        conv_start = 1'b1;
                        state_next = ST_CONV;
                    end else begin
                        hex_load   = 1'b1;
                    end
                end
            end
            ST_CONV: begin
                if (conv_done) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.busy = (state != ST_IDLE);

    bin2bcd_iter u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (bus.value),
        .done  (conv_done),
        .bcd   (bcd)
    );

    assign {hund, tens, ones} = bcd;

    // Display registers change only on a hex load or a decimal commit, all digits at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the digit array is reset explicitly because its reset contents are displayed.
            for (int i = 1; i < NUM_DIGITS; i++) begin
                digits[i] <= DIGIT_BLANK;
            end
            digits[0] <= DIGIT_ZERO;
        end else if (hex_load) begin
            for (int i = 2; i < NUM_DIGITS; i++) begin
                digits[i] <= DIGIT_BLANK;
            end
            digits[1] <= mk_digit(1'b0, bus.value[7:4]);
            digits[0] <= mk_digit(1'b0, bus.value[3:0]);
        end else if (commit) begin
            for (int i = 3; i < NUM_DIGITS; i++) begin
                digits[i] <= DIGIT_BLANK;
            end
            digits[2] <= mk_digit(hund == 4'd0, hund);
            digits[1] <= mk_digit((hund == 4'd0) && (tens == 4'd0), tens);
            digits[0] <= mk_digit(1'b0, ones);
        end
    end

    // Digit enable and glyph both follow digit_idx, so they always change together.
    always_comb begin
        an  = NUM_DIGITS'(1) << digit_idx;
        seg = digits[digit_idx].blank ? SEG_BLANK : HEX_GLYPH[digits[digit_idx].val];
    end

endmodule

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 Parameter: SCAN_DIV, default 100000, clock cycles each digit is lit (1 ms at 100 MHz).
REQ-002 Parameter: NUM_DIGITS, fixed at 4, number of scanned digit positions.
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 value  input  8  binary number to display.
REQ-006 load  input  1  single-cycle pulse that captures value and mode_dec, e.g. from the debounced key pulse.
REQ-007 mode_dec  input  1  display format: 1 = decimal, 0 = hexadecimal.
REQ-008 busy  output  1  high while a decimal conversion is in progress.
REQ-009 an  output  4  one-hot active-high digit enable; an[0] is the rightmost digit.
REQ-010 seg  output  8  active-high segments {a,b,c,d,e,f,g,dp}; seg[7]=a; dp always 0.

Function
REQ-011 Scan counter SHALL count 0..SCAN_DIV-1 every cycle and wrap; on wrap, digit index SHALL advance 0->1->2->3->0.
REQ-012 an SHALL equal one-hot(digit index) at all times; seg SHALL be the pattern of the displayed digit register at that index (registered, 1-cycle delay acceptable if consistent with an).
REQ-013 Blank digit: seg = 8'h00 while its an bit is still asserted.
REQ-014 FSM states: IDLE, CONV, COMMIT.
REQ-015 IDLE + load + mode_dec=0 -> display regs SHALL update on the next edge: digit1 = value[7:4], digit0 = value[3:0], digits 3..2 blank, no leading-zero blanking; busy stays 0.
REQ-016 IDLE + load + mode_dec=1 -> capture value, enter CONV; busy SHALL be 1 from the next edge.
REQ-017 CONV SHALL run exactly 8 cycles of shift-add-3 (double dabble) on a 12-bit BCD accumulator, then go to COMMIT.
REQ-018 COMMIT (1 cycle) SHALL write hundreds/tens/ones to digits 2/1/0 and blank digit 3, then return to IDLE; busy falls on the same edge the display regs update (busy high for exactly 9 cycles).
REQ-019 Decimal leading-zero blanking: hundreds blank if 0; tens blank if hundreds and tens are both 0; ones always shown.
REQ-020 Display regs SHALL hold their previous contents throughout CONV; no partial digit updates are ever visible.
REQ-021 load while busy=1 SHALL be ignored (no queueing), regardless of mode_dec.
REQ-022 Scan timing SHALL be independent of load/FSM activity; no scan restart on load.
REQ-023 Hex glyphs 0-9, A, b, C, d, E, F: standard patterns, e.g. 0 = 8'hFC, 8 = 8'hFE, F = 8'h8E.

Reset
REQ-024 rst SHALL override all inputs, including load in the same cycle.
REQ-025 After reset:
- state IDLE, busy 0
- scan counter 0, digit index 0, an 4'b0001
- digit0 = 0, digits 3..1 blank
- seg = 8'hFC while an[0] is active.
REQ-026 rst asserted during CONV or COMMIT SHALL abort the conversion; display shows reset contents, never the converted value.

Structure
REQ-027 Shared package seg_pkg SHALL hold:
- FSM state enum
- the 16 hex glyph constants and SEG_BLANK
- the default SCAN_DIV.
REQ-028 One sub-module, bin2bcd_iter, SHALL implement the 8-cycle shift-add-3 converter with start/done handshake; glyph lookup stays combinational in the top.

Verification (SCAN_DIV=4 for simulation)
REQ-029 Reset, no load -> an cycles 0001,0010,0100,1000 every 4 clks; seg = FC on an=0001, 00 on the others.
REQ-030 load, value=8'h3F, mode_dec=0 -> next edge digits "  3F"; seg = 8'hF2 on an[1], 8'h8E on an[0]; busy never 1.
REQ-031 load, value=255, mode_dec=1 -> busy high 9 cycles; on its fall digits " 255"; old digits visible until then.
REQ-032 load, value=7, mode_dec=1 -> "   7" (hundreds/tens blank); then value=100 -> " 100".
REQ-033 second load 3 cycles into a decimal conversion -> ignored; result matches the first value; busy still 9 cycles.
REQ-034 rst pulse at cycle 4 of CONV for value=200 -> busy 0 next edge; display "   0"; a later load works normally.
